// File: rtl/pipe_rate_pwr_ctrl.sv
// PIPE rate / power-state sequencer.
// Accepts one LTSSM request at a time and applies the Rate/PCLKRate change
// first, then the PowerDown change. Each phase runs the PHY handshake and
// waits for PhyStatus on every masked lane. The requester gets a one-cycle
// done pulse on success, or a one-cycle timeout_err pulse if a wait stalls.
module pipe_rate_pwr_ctrl #(
  parameter int          LANESNUMBER    = 16,
  parameter int          TIMEOUT_CYCLES = 4096,
  parameter logic [3:0]  RESET_PD       = 4'h2
) (
  input  logic                     CLK,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [3:0]               req_rate,
  input  logic [4:0]               req_pclkrate,
  input  logic [3:0]               req_powerdown,
  input  logic [LANESNUMBER-1:0]   active_lanes,
  output logic                     done,
  output logic                     timeout_err,
  output logic [3:0]               Rate,
  output logic [4:0]               PCLKRate,
  output logic [4*LANESNUMBER-1:0] PowerDown,
  output logic                     PclkChangeAck,
  input  logic                     PclkChangeOk,
  input  logic [LANESNUMBER-1:0]   PhyStatus
);

  localparam int             CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  // S_DECIDE compares the latched request against what is currently driven.
  typedef enum logic [2:0] {
    S_IDLE,
    S_DECIDE,
    S_APPLY_RATE,
    S_WAIT_OK,
    S_APPLY_PD,
    S_WAIT_STATUS,
    S_COMPLETE
  } state_t;

  state_t                  r_state,      w_state_next;
  logic [3:0]              r_req_rate,   w_req_rate_next;
  logic [4:0]              r_req_pclk,   w_req_pclk_next;
  logic [3:0]              r_req_pd,     w_req_pd_next;
  logic [LANESNUMBER-1:0]  r_mask,       w_mask_next;
  logic                    r_pd_pending, w_pd_pending_next;
  logic [LANESNUMBER-1:0]  r_sticky,     w_sticky_next;
  logic [CW-1:0]           r_cnt,        w_cnt_next;
  logic [3:0]              r_rate,       w_rate_next;
  logic [4:0]              r_pclkrate,   w_pclkrate_next;
  logic [3:0]              r_pd,         w_pd_next;
  logic                    r_ack,        w_ack_next;
  logic                    r_done,       w_done_next;
  logic                    r_timeout,    w_timeout_next;

  logic [LANESNUMBER-1:0]  w_phy_masked;
  logic                    w_all_seen;
  logic                    w_cnt_last;

  // A lane that reports in the same cycle as the check still counts.
  assign w_phy_masked = PhyStatus & r_mask;
  assign w_all_seen   = ((r_sticky | w_phy_masked) == r_mask);
  assign w_cnt_last   = (r_cnt == CNT_LAST);

  // State and output registers; reset drops everything to the idle P1 state at once.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_req_rate   <= '0;
      r_req_pclk   <= '0;
      r_req_pd     <= '0;
      r_mask       <= '0;
      r_pd_pending <= 1'b0;
      r_sticky     <= '0;
      r_cnt        <= '0;
      r_rate       <= '0;
      r_pclkrate   <= '0;
      r_pd         <= RESET_PD;
      r_ack        <= 1'b0;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_req_rate   <= w_req_rate_next;
      r_req_pclk   <= w_req_pclk_next;
      r_req_pd     <= w_req_pd_next;
      r_mask       <= w_mask_next;
      r_pd_pending <= w_pd_pending_next;
      r_sticky     <= w_sticky_next;
      r_cnt        <= w_cnt_next;
      r_rate       <= w_rate_next;
      r_pclkrate   <= w_pclkrate_next;
      r_pd         <= w_pd_next;
      r_ack        <= w_ack_next;
      r_done       <= w_done_next;
      r_timeout    <= w_timeout_next;
    end
  end

  // Next-state and next-output logic; PIPE controls change on entry to the APPLY states.
  always_comb begin
    w_state_next      = r_state;
    w_req_rate_next   = r_req_rate;
    w_req_pclk_next   = r_req_pclk;
    w_req_pd_next     = r_req_pd;
    w_mask_next       = r_mask;
    w_pd_pending_next = r_pd_pending;
    w_sticky_next     = r_sticky;
    w_cnt_next        = r_cnt;
    w_rate_next       = r_rate;
    w_pclkrate_next   = r_pclkrate;
    w_pd_next         = r_pd;
    w_ack_next        = r_ack;
    w_done_next       = 1'b0;
    w_timeout_next    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_req_rate_next = req_rate;
          w_req_pclk_next = req_pclkrate;
          w_req_pd_next   = req_powerdown;
          w_mask_next     = active_lanes;
          w_state_next    = S_DECIDE;
        end
      end

      S_DECIDE: begin
        if (r_mask == '0) begin
          // Nothing to collect from, so the PIPE outputs are left alone.
          w_done_next  = 1'b1;
          w_state_next = S_IDLE;
        end else if ((r_req_rate != r_rate) || (r_req_pclk != r_pclkrate)) begin
          w_rate_next       = r_req_rate;
          w_pclkrate_next   = r_req_pclk;
          w_pd_pending_next = (r_req_pd != r_pd);
          w_state_next      = S_APPLY_RATE;
        end else if (r_req_pd != r_pd) begin
          w_pd_next         = r_req_pd;
          w_pd_pending_next = 1'b0;
          w_state_next      = S_APPLY_PD;
        end else begin
          w_done_next  = 1'b1;
          w_state_next = S_IDLE;
        end
      end

      S_APPLY_RATE: begin
        w_sticky_next = '0;
        w_cnt_next    = '0;
        w_state_next  = S_WAIT_OK;
      end

      S_WAIT_OK: begin
        if (PclkChangeOk) begin
          // Early PhyStatus seen while waiting for Ok must not be counted.
          w_ack_next    = 1'b1;
          w_sticky_next = '0;
          w_cnt_next    = '0;
          w_state_next  = S_WAIT_STATUS;
        end else if (w_cnt_last) begin
          w_timeout_next = 1'b1;
          w_ack_next     = 1'b0;
          w_state_next   = S_IDLE;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end

      S_APPLY_PD: begin
        w_sticky_next = '0;
        w_cnt_next    = '0;
        w_state_next  = S_WAIT_STATUS;
      end

      S_WAIT_STATUS: begin
        if (w_all_seen) begin
          // done lines up with the COMPLETE cycle when no PD phase follows.
          w_ack_next   = 1'b0;
          w_done_next  = !r_pd_pending;
          w_state_next = S_COMPLETE;
        end else if (w_cnt_last) begin
          w_timeout_next = 1'b1;
          w_ack_next     = 1'b0;
          w_state_next   = S_IDLE;
        end else begin
          w_sticky_next = r_sticky | w_phy_masked;
          w_cnt_next    = r_cnt + CW'(1);
        end
      end

      S_COMPLETE: begin
        w_ack_next = 1'b0;
        if (r_pd_pending) begin
          w_pd_next         = r_req_pd;
          w_pd_pending_next = 1'b0;
          w_state_next      = S_APPLY_PD;
        end else begin
          w_state_next = S_IDLE;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign req_ready     = (r_state == S_IDLE);
  assign done          = r_done;
  assign timeout_err   = r_timeout;
  assign Rate          = r_rate;
  assign PCLKRate      = r_pclkrate;
  assign PclkChangeAck = r_ack;

  // Every lane carries the same PowerDown code.
  generate
    for (genvar gi = 0; gi < LANESNUMBER; gi++) begin : g_pd_lane
      assign PowerDown[gi*4 +: 4] = r_pd;
    end
  endgenerate

endmodule
